// File: rtl/send_numbers.sv
// Transmit-side formatter: latches an NDIGITS hex value and writes it to the UART TX FIFO as ASCII, MSD first.
// Define SEND_NUMBERS_CRLF_EN to append a CR/LF terminator (TERM state) to every sequence.
module send_numbers #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
`ifdef SEND_NUMBERS_CRLF_EN
    TERM = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q;
  logic [CW-1:0]   cnt_q;
`ifdef SEND_NUMBERS_CRLF_EN
  logic            term_q;
`endif

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath only advances on an actual FIFO write, so a stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef SEND_NUMBERS_CRLF_EN
      term_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= value;
            cnt_q   <= CW'(NDIGITS);
`ifdef SEND_NUMBERS_CRLF_EN
            term_q  <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (!tx_full) begin
            shift_q <= shift_q << 4;
            cnt_q   <= cnt_q - CW'(1);
          end
        end
`ifdef SEND_NUMBERS_CRLF_EN
        TERM: begin
          if (!tx_full) term_q <= ~term_q;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SEND;
      end
      SEND: begin
        w_data  = to_ascii(shift_q[W-1 -: 4]);
        wr_uart = !tx_full;
        if (!tx_full && cnt_q == CW'(1)) begin
`ifdef SEND_NUMBERS_CRLF_EN
          state_d = TERM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SEND_NUMBERS_CRLF_EN
      // term_q selects CR first, then LF.
      TERM: begin
        w_data  = term_q ? 8'h0A : 8'h0D;
        wr_uart = !tx_full;
        if (!tx_full && term_q) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/send_numbers.md
# send_numbers

Transmit-side formatter: latches a multi-digit hex value and writes it to the UART transmit FIFO as ASCII hex characters, most-significant digit first. It is the transmit counterpart of the receive-path ASCII-to-nibble assembler. It sits between the display/value register and the `uart` block's `wr_uart`/`w_data`/`tx_full` write port.

## Interface
- `NDIGITS`, 4: number of hex digits sent per request; legal range 1–8.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: request pulse; sampled only in IDLE.
- `value  in  4*NDIGITS`: value to send; latched on accepted `start`.
- `tx_full  in  1`: UART TX FIFO full; no write occurs while high.
- `wr_uart  out  1`: FIFO write strobe; one byte is written per high cycle.
- `w_data  out  8`: ASCII byte; valid whenever `wr_uart` is high.
- `busy  out  1`: high from the cycle after `start` is accepted through the DONE cycle.
- `done  out  1`: one-cycle pulse after the last byte is written.

## Operation
- **State machine:** IDLE, SEND, TERM (only with the macro defined), DONE.
- **IDLE:**
  - `start`=1 latches `value` into the shift register and loads the digit counter with `NDIGITS`.
  - The FSM then moves to SEND.
- **SEND:**
  - `w_data` = ASCII of the shift register's top nibble:
    - 0x0–0x9 → 0x30–0x39
    - 0xA–0xF → 0x41–0x46 (uppercase)
  - `wr_uart` = !`tx_full`. This is a combinational path from `tx_full`; there is no other combinational input-to-output path.
  - On each write, the shift register shifts left 4 bits and the counter decrements.
  - After the write made with counter = 1, the FSM goes to TERM if the macro is defined, otherwise to DONE.
- **TERM:** writes 0x0D and then 0x0A under the same `tx_full` rule, then goes to DONE.
- **DONE:** `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
- **Ignored inputs:**
  - `start` while not in IDLE is ignored; it is neither queued nor allowed to restart the sequence.
  - Changes on `value` after latch are ignored.
- **`tx_full` stalls:**
  - `tx_full` high in SEND/TERM stalls indefinitely.
  - During a stall, `w_data` holds and the counter and shift register do not change.
- **Outside SEND/TERM:** `wr_uart`=0 and `w_data`=0x00.
- **Reset (including mid-sequence):**
  - The FSM returns to IDLE immediately.
  - `wr_uart`=0, `w_data`=0x00, `busy`=0, `done`=0, shift register and counter cleared.
  - Partially sent bytes are not retransmitted.

## Timing
- `start` accepted at edge k: `busy`=1 and the first `wr_uart` can be high in cycle k+1.
- With `tx_full` held low, writes are back-to-back, one byte per cycle.
- Cycles from accepted `start` to `done` pulse:
  - Without the macro: `NDIGITS`+1.
  - With the macro: `NDIGITS`+3.
- Each stall cycle adds one cycle to that total.
- `start` asserted in the DONE cycle is ignored; `start` in the first IDLE cycle after DONE is accepted.
- `tx_full` is treated as valid in the same cycle the write occurs, since the FIFO reflects its own full status.

## Configuration
- **`SEND_NUMBERS_CRLF_EN` defined:**
  - The TERM state exists.
  - Every sequence ends with 0x0D, 0x0A.
  - A sequence is `NDIGITS`+2 bytes.
- **`SEND_NUMBERS_CRLF_EN` undefined:**
  - The TERM state is not built.
  - A sequence is exactly `NDIGITS` bytes, and SEND goes straight to DONE.

## Test plan
- **Basic send:** reset, `value`=0x1A3F, `start` pulse, `tx_full`=0.
  - Bytes 0x31, 0x41, 0x33, 0x46 on consecutive cycles, plus 0x0D, 0x0A when the macro is defined.
  - `done` pulses once, then `busy`=0.
- **Digit coverage:** `value`=0x09AF, then 0xFFFF, then 0x0000.
  - Bytes 0x30,0x39,0x41,0x46 / 0x46×4 / 0x30×4.
  - Checks every ASCII range boundary.
- **Stall:** `value`=0xBEEF, `tx_full` high for 3 cycles after the second byte.
  - Byte 0x45 is held on `w_data` with `wr_uart`=0 for 3 cycles.
  - Output stream is still 0x42,0x45,0x45,0x46.
  - `done` is delayed by 3 cycles.
- **Ignored start / re-arm:** `value`=0x1234 with `start`, then `value`=0x5678 with `start` repulsed mid-sequence and again in the DONE cycle.
  - Only 0x31,0x32,0x33,0x34 are sent.
  - `start` in the following IDLE cycle sends 0x35..0x38.
- **Reset mid-operation:** drop `rst_n` after two bytes of 0xCAFE.
  - `wr_uart`, `busy`, `done` go 0 immediately.
  - A new `start` with 0x0001 sends 0x30,0x30,0x30,0x31.
- **Parameter sweep:** `NDIGITS`=1 with `value`=0xA gives a single 0x41, with `done` 2 cycles after `start` when the macro is undefined.
